// File: rtl/ov7670_pixel_bus_tx.sv
// OV7670-style pixel bus emulator: PCLK = CLOCK/2, VSYNC/HREF/D registered and updated only on PCLK falling ticks.
// No backpressure: runs free-running frames while EN is high; EN is honoured only between frames.
module ov7670_pixel_bus_tx #(
  parameter int H_ACTIVE      = 176,
  parameter int V_ACTIVE      = 144,
  parameter int VSYNC_TICKS   = 1536,
  parameter int V_BACK_TICKS  = 512,
  parameter int H_BLANK_TICKS = 144,
  parameter int V_FRONT_TICKS = 256
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        EN,
  input  logic [1:0]  MODE,
  input  logic [15:0] COLOR,
  output logic        PCLK_OUT,
  output logic        VSYNC,
  output logic        HREF,
  output logic [7:0]  D,
  output logic        FRAME_DONE,
  output logic [7:0]  FRAME_CNT
);

  typedef enum logic [2:0] {IDLE, VS, VBP, ACT, HBL, VFP} state_t;

  localparam logic [15:0] VS_LAST   = 16'(VSYNC_TICKS - 1);
  localparam logic [15:0] VBP_LAST  = 16'(V_BACK_TICKS - 1);
  localparam logic [15:0] ACT_LAST  = 16'(2 * H_ACTIVE - 1);
  localparam logic [15:0] HBL_LAST  = 16'(H_BLANK_TICKS - 1);
  localparam logic [15:0] VFP_LAST  = 16'(V_FRONT_TICKS - 1);
  localparam logic [15:0] BAR_LAST  = 16'(H_ACTIVE / 8 - 1);
  localparam logic [15:0] LINE_LAST = 16'(V_ACTIVE - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] line_q, line_d;
  logic [2:0]  bar_q, bar_d;
  logic [15:0] barw_q, barw_d;
  logic [1:0]  mode_q, mode_d;
  logic [15:0] color_q, color_d;
  logic        pclk_q, pclk_d;
  logic        vsync_q, vsync_d;
  logic        href_q, href_d;
  logic [7:0]  dat_q, dat_d;
  logic        done_q, done_d;
  logic [7:0]  fcnt_q, fcnt_d;
  logic [15:0] pix;
  logic [7:0]  x;

  function automatic logic [15:0] bar_color(input logic [2:0] b);
    case (b)
      3'd0:    bar_color = 16'hFFFF;
      3'd1:    bar_color = 16'hFFE0;
      3'd2:    bar_color = 16'h07FF;
      3'd3:    bar_color = 16'h07E0;
      3'd4:    bar_color = 16'hF81F;
      3'd5:    bar_color = 16'hF800;
      3'd6:    bar_color = 16'h001F;
      default: bar_color = 16'h0000;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    bar_d   = bar_q;
    barw_d  = barw_q;
    mode_d  = mode_q;
    color_d = color_q;
    pclk_d  = ~pclk_q;
    vsync_d = vsync_q;
    href_d  = href_q;
    dat_d   = dat_q;
    done_d  = 1'b0;
    fcnt_d  = fcnt_q;
    pix     = 16'h0000;
    x       = 8'h00;

    // A tick is the edge where PCLK falls; all bus state advances only here.
    if (pclk_q) begin
      cnt_d = cnt_q + 16'd1;
      case (state_q)
        IDLE: begin
          cnt_d = 16'd0;
          if (EN) begin
            state_d = VS;
            mode_d  = MODE;
            color_d = COLOR;
          end
        end
        VS: if (cnt_q == VS_LAST) begin
          state_d = VBP;
          cnt_d   = 16'd0;
        end
        VBP: if (cnt_q == VBP_LAST) begin
          state_d = ACT;
          cnt_d   = 16'd0;
          line_d  = 16'd0;
          bar_d   = 3'd0;
          barw_d  = 16'd0;
        end
        ACT: begin
          if (cnt_q == ACT_LAST) begin
            state_d = HBL;
            cnt_d   = 16'd0;
          end else if (cnt_q[0]) begin
            // Second byte of a pixel done: step the bar width counter.
            if (barw_q == BAR_LAST) begin
              barw_d = 16'd0;
              bar_d  = bar_q + 3'd1;
            end else begin
              barw_d = barw_q + 16'd1;
            end
          end
        end
        HBL: if (cnt_q == HBL_LAST) begin
          cnt_d  = 16'd0;
          bar_d  = 3'd0;
          barw_d = 16'd0;
          if (line_q == LINE_LAST) begin
            state_d = VFP;
          end else begin
            state_d = ACT;
            line_d  = line_q + 16'd1;
          end
        end
        VFP: if (cnt_q == VFP_LAST) begin
          cnt_d  = 16'd0;
          done_d = 1'b1;
          fcnt_d = fcnt_q + 8'd1;
          if (EN) begin
            state_d = VS;
            mode_d  = MODE;
            color_d = COLOR;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      x = cnt_d[8:1];
      case (mode_d)
        2'd0:    pix = color_d;
        2'd1:    pix = bar_color(bar_d);
        2'd2:    pix = {x[7:3], 6'b000000, line_d[7:3]};
        default: pix = (x[3] ^ line_d[3]) ? 16'hFFFF : 16'h0000;
      endcase

      vsync_d = (state_d == VS);
      href_d  = (state_d == ACT);
      dat_d   = href_d ? (cnt_d[0] ? pix[7:0] : pix[15:8]) : 8'h00;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      line_q  <= 16'd0;
      bar_q   <= 3'd0;
      barw_q  <= 16'd0;
      mode_q  <= 2'd0;
      color_q <= 16'h0000;
      pclk_q  <= 1'b0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      dat_q   <= 8'h00;
      done_q  <= 1'b0;
      fcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      bar_q   <= bar_d;
      barw_q  <= barw_d;
      mode_q  <= mode_d;
      color_q <= color_d;
      pclk_q  <= pclk_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      dat_q   <= dat_d;
      done_q  <= done_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign PCLK_OUT   = pclk_q;
  assign VSYNC      = vsync_q;
  assign HREF       = href_q;
  assign D          = dat_q;
  assign FRAME_DONE = done_q;
  assign FRAME_CNT  = fcnt_q;

endmodule

// File: tb/tb_ov7670_pixel_bus_tx.sv
// Bench for ov7670_pixel_bus_tx: per-tick comparison of the pixel bus against a frame-timing reference model.
// A second, tiny-frame instance runs 256 frames to exercise the FRAME_CNT wrap.
module tb_ov7670_pixel_bus_tx;

  localparam int H   = 16;
  localparam int V   = 10;
  localparam int VST = 6;
  localparam int VBT = 4;
  localparam int HBT = 3;
  localparam int VFT = 5;
  localparam int LINE_T  = 2 * H + HBT;
  localparam int FRAME_T = VST + VBT + V * LINE_T + VFT;
  localparam int FRAME_W = 2 + 2 + 2 * (2 * 8 + 2) + 2;

  localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                       16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst_w = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] color = 16'h0000;
  logic        pclk, vsync, href, done;
  logic [7:0]  d, fcnt;
  logic        w_pclk, w_vsync, w_href, w_done;
  logic [7:0]  w_d, w_fcnt;

  int          nassert = 0;
  int          nfail = 0;
  logic        last_pclk = 1'b0;
  logic        s_vsync = 1'b0, s_href = 1'b0;
  logic [7:0]  s_d = 8'h00;
  logic        done_pending = 1'b0;
  logic [7:0]  exp_cnt = 8'd0;
  logic [7:0]  cap0 [2*H];
  logic [7:0]  cap8 [2*H];

  always #5 clk = ~clk;

  ov7670_pixel_bus_tx #(
    .H_ACTIVE(H), .V_ACTIVE(V), .VSYNC_TICKS(VST), .V_BACK_TICKS(VBT),
    .H_BLANK_TICKS(HBT), .V_FRONT_TICKS(VFT)
  ) dut (
    .CLOCK(clk), .RESET(rst_n), .EN(en), .MODE(mode), .COLOR(color),
    .PCLK_OUT(pclk), .VSYNC(vsync), .HREF(href), .D(d),
    .FRAME_DONE(done), .FRAME_CNT(fcnt)
  );

  ov7670_pixel_bus_tx #(
    .H_ACTIVE(8), .V_ACTIVE(2), .VSYNC_TICKS(2), .V_BACK_TICKS(2),
    .H_BLANK_TICKS(2), .V_FRONT_TICKS(2)
  ) dut_w (
    .CLOCK(clk), .RESET(rst_w), .EN(1'b1), .MODE(2'd1), .COLOR(16'h0000),
    .PCLK_OUT(w_pclk), .VSYNC(w_vsync), .HREF(w_href), .D(w_d),
    .FRAME_DONE(w_done), .FRAME_CNT(w_fcnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next PCLK falling tick; between ticks the bus must hold.
  task automatic tick();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (!pclk && last_pclk) begin
        got = 1'b1;
      end else begin
        chk("stable", {22'd0, vsync, href, d}, {22'd0, s_vsync, s_href, s_d});
        chk("done_width", {31'd0, done}, 32'd0);
      end
      last_pclk = pclk;
    end
    chk("tick_seen", {31'd0, got}, 32'd1);
    s_vsync = vsync;
    s_href  = href;
    s_d     = d;
  endtask

  function automatic logic [15:0] pix_model(input int m, input logic [15:0] c, input int x, input int y);
    case (m)
      0:       return c;
      1:       return BARS[x / (H / 8)];
      2:       return 16'((((x >> 3) & 31) << 11) | ((y >> 3) & 31));
      default: return ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  // Expected {VSYNC, HREF, D} for tick t of a frame, t = 0 being the first VSYNC tick.
  function automatic logic [9:0] exp_out(input int m, input logic [15:0] c, input int t);
    int r, y, p;
    logic [15:0] px;
    if (t < VST) return 10'h200;
    r = t - VST - VBT;
    if (r < 0 || r >= V * LINE_T) return 10'h000;
    y = r / LINE_T;
    p = r % LINE_T;
    if (p >= 2 * H) return 10'h000;
    px = pix_model(m, c, p / 2, y);
    return {2'b01, (p % 2 == 1) ? px[7:0] : px[15:8]};
  endfunction

  task automatic run_frame(input int chg_t, input logic [1:0] nm, input logic [15:0] nc, input int drop_t);
    int m, r, hp, ht;
    logic [15:0] c;
    logic prev_href;
    m = int'(mode);
    c = color;
    hp = 0;
    ht = 0;
    prev_href = 1'b0;
    for (int t = 0; t < FRAME_T; t++) begin
      tick();
      if (t == 0) begin
        if (done_pending) exp_cnt = exp_cnt + 8'd1;
        chk("frame_done", {31'd0, done}, {31'd0, done_pending});
        done_pending = 1'b0;
      end
      chk("frame_cnt", {24'd0, fcnt}, {24'd0, exp_cnt});
      chk("pixbus", {22'd0, vsync, href, d}, {22'd0, exp_out(m, c, t)});
      if (href && !prev_href) hp++;
      if (href) ht++;
      prev_href = href;
      r = t - VST - VBT;
      if (r >= 0 && r < V * LINE_T && (r % LINE_T) < 2 * H) begin
        if (r / LINE_T == 0) cap0[r % LINE_T] = d;
        if (r / LINE_T == 8) cap8[r % LINE_T] = d;
      end
      if (t == chg_t) begin
        mode  = nm;
        color = nc;
      end
      if (t == drop_t) en = 1'b0;
    end
    chk("href_pulses", hp, V);
    chk("href_ticks", ht, V * 2 * H);
    done_pending = 1'b1;
  endtask

  initial begin
    int nd;
    en = 1'b1;
    mode = 2'd0;
    color = 16'hF800;
    repeat (5) begin
      @(negedge clk);
      chk("reset_out", {13'd0, pclk, vsync, href, d, done, fcnt}, 32'd0);
    end
    chk("reset_w", {13'd0, w_pclk, w_vsync, w_href, w_d, w_done, w_fcnt}, 32'd0);
    rst_n = 1'b1;
    last_pclk = 1'b0;

    // Solid F800; MODE flips to bars mid-frame and must only apply next frame.
    run_frame(100, 2'd1, 16'h1234, -1);

    run_frame(150, 2'd3, 16'($urandom), -1);
    chk("bar_px0", {16'd0, cap0[0], cap0[1]}, 32'hFFFF);
    chk("bar_px1", {16'd0, cap0[2], cap0[3]}, 32'hFFFF);
    chk("bar_px2", {16'd0, cap0[4], cap0[5]}, 32'hFFE0);
    chk("bar_px4_hi", {24'd0, cap0[8]}, 32'h07);
    chk("bar_px4_lo", {24'd0, cap0[9]}, 32'hFF);
    chk("bar_last", {16'd0, cap0[2*H-2], cap0[2*H-1]}, 32'h0000);

    run_frame(200, 2'd0, 16'($urandom), -1);
    chk("chk_l0_px8", {16'd0, cap0[16], cap0[17]}, 32'hFFFF);
    chk("chk_l8_px8", {16'd0, cap8[16], cap8[17]}, 32'h0000);

    for (int i = 0; i < 3; i++) begin
      run_frame(int'($urandom_range(1, FRAME_T - 1)), 2'($urandom), 16'($urandom), -1);
    end

    // Drop EN during line 5: frame completes, then the bus idles.
    run_frame(-1, 2'd0, 16'h0000, VST + VBT + 5 * LINE_T + 3);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) exp_cnt = exp_cnt + 8'd1;
      chk("idle_done", {31'd0, done}, (i == 0) ? 32'd1 : 32'd0);
      chk("idle_bus", {22'd0, vsync, href, d}, 32'd0);
      chk("idle_cnt", {24'd0, fcnt}, {24'd0, exp_cnt});
    end
    done_pending = 1'b0;
    en = 1'b1;
    mode = 2'($urandom);
    color = 16'($urandom);
    run_frame(-1, 2'd0, 16'h0000, -1);

    for (int i = 0; i < FRAME_T && !href; i++) tick();
    chk("reach_act", {31'd0, href}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset", {13'd0, pclk, vsync, href, d, done, fcnt}, 32'd0);

    rst_w = 1'b1;
    nd = 0;
    for (int i = 0; i < 256 * 2 * FRAME_W + 200 && nd < 256; i++) begin
      @(negedge clk);
      if (w_done) begin
        nd++;
        chk("wrap_cnt", {24'd0, w_fcnt}, nd % 256);
      end
    end
    chk("wrap_frames", nd, 256);
    chk("wrap_zero", {24'd0, w_fcnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
